// File: rtl/sha1_hash_core_if.sv
// Port A of the word-wide single-port SRAM, driven by the SHA-1 core as bus master.
interface sha1_hash_core_if;
    logic        port_A_clk;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;
    logic [15:0] port_A_addr;
    logic        port_A_we;

    modport master (
        output port_A_clk,
        output port_A_data_in,
        input  port_A_data_out,
        output port_A_addr,
        output port_A_we
    );

    modport slave (
        input  port_A_clk,
        input  port_A_data_in,
        output port_A_data_out,
        input  port_A_addr,
        input  port_A_we
    );
endinterface

// File: rtl/sha1_hash_core.sv
// SHA-1 co-processor: fetches a byte message from SRAM port A, pads it in-line,
// runs 80 rounds per 512-bit block and presents the 160-bit digest with done.
module sha1_hash_core (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_hash,
    input  logic [31:0]      message_addr,
    input  logic [31:0]      message_size,
    output logic [159:0]     hash,
    output logic             done,
    sha1_hash_core_if.master port_a
);

    localparam logic [31:0] H0_INIT = 32'h67452301;
    localparam logic [31:0] H1_INIT = 32'hEFCDAB89;
    localparam logic [31:0] H2_INIT = 32'h98BADCFE;
    localparam logic [31:0] H3_INIT = 32'h10325476;
    localparam logic [31:0] H4_INIT = 32'hC3D2E1F0;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StPad,
        StRounds,
        StUpdate,
        StDone
    } state_e;

    state_e       r_state;
    logic [15:0]  r_base;
    logic [31:0]  r_size;
    logic [10:0]  r_nblk;
    logic [10:0]  r_blk;
    logic [4:0]   r_issue;
    logic [4:0]   r_recv;
    logic         r_p1;
    logic         r_p2;
    logic [15:0]  r_addr;
    logic [6:0]   r_t;
    logic [31:0]  r_a, r_b, r_c, r_d, r_e;
    logic [31:0]  r_h0, r_h1, r_h2, r_h3, r_h4;
    logic [31:0]  r_w [16];
    logic [159:0] r_hash;
    logic         r_done;

    logic [16:0]  w_nblk_sum;
    logic [10:0]  w_nblk_new;
    logic [16:0]  w_size17;
    logic [16:0]  w_issue_off;
    logic [16:0]  w_recv_off;
    logic [16:0]  w_recv_left;
    logic [15:0]  w_addr_sum;
    logic         w_do_issue;
    logic         w_last_blk;
    logic [31:0]  w_swap;
    logic [31:0]  w_recv_word;
    logic [31:0]  w_pad_word;
    logic [3:0]   w_widx, w_i3, w_i8, w_i14;
    logic [31:0]  w_sched_x;
    logic [31:0]  w_sched;
    logic [31:0]  w_wt;
    logic [31:0]  w_f;
    logic [31:0]  w_k;
    logic [31:0]  w_temp;
    logic [31:0]  w_h0n, w_h1n, w_h2n, w_h3n, w_h4n;
    logic         w_unused_addr;

    // Memory port is read-only; the core only ever drives addresses.
    assign port_a.port_A_clk     = clk;
    assign port_a.port_A_data_in = 32'h0;
    assign port_a.port_A_we      = 1'b0;
    assign port_a.port_A_addr    = r_addr;

    assign hash = r_hash;
    assign done = r_done;

    assign w_unused_addr = ^message_addr[31:16];

    // Block count and per-word byte offsets within the padded message.
    always_comb begin
        w_nblk_sum  = {1'b0, message_size[15:0]} + 17'd8;
        w_nblk_new  = w_nblk_sum[16:6] + 11'd1;
        w_size17    = {1'b0, r_size[15:0]};
        w_issue_off = {r_blk, r_issue[3:0], 2'b00};
        w_recv_off  = {r_blk, r_recv[3:0], 2'b00};
        w_recv_left = w_size17 - w_recv_off;
        w_addr_sum  = r_base + w_issue_off[15:0];
        w_last_blk  = (r_blk == (r_nblk - 11'd1));
        // Only words holding at least one message byte are fetched.
        w_do_issue  = (r_state == StRead) && !r_issue[4] && (w_issue_off < w_size17);
    end

    // Byte-swap the fetched word and mask a partial final message word.
    always_comb begin
        w_swap = {port_a.port_A_data_out[7:0], port_a.port_A_data_out[15:8],
                  port_a.port_A_data_out[23:16], port_a.port_A_data_out[31:24]};
        w_recv_word = w_swap;
        if (w_recv_left < 17'd4) begin
            case (r_size[1:0])
                2'd1:    w_recv_word = (w_swap & 32'hFF000000) | 32'h00800000;
                2'd2:    w_recv_word = (w_swap & 32'hFFFF0000) | 32'h00008000;
                2'd3:    w_recv_word = (w_swap & 32'hFFFFFF00) | 32'h00000080;
                default: w_recv_word = w_swap;
            endcase
        end
    end

    // Padding words that need no memory access: length words, 0x80 marker, zeros.
    always_comb begin
        w_pad_word = 32'h0;
        if (w_last_blk && (r_recv[3:0] == 4'd14)) begin
            w_pad_word = {29'h0, r_size[31:29]};
        end else if (w_last_blk && (r_recv[3:0] == 4'd15)) begin
            w_pad_word = {r_size[28:0], 3'b000};
        end else if (w_recv_off == w_size17) begin
            w_pad_word = 32'h80000000;
        end
    end

    // Message schedule out of the 16-entry circular buffer and the round function.
    always_comb begin
        w_widx    = r_t[3:0];
        w_i3      = w_widx + 4'd13;
        w_i8      = w_widx + 4'd8;
        w_i14     = w_widx + 4'd2;
        w_sched_x = r_w[w_i3] ^ r_w[w_i8] ^ r_w[w_i14] ^ r_w[w_widx];
        w_sched   = {w_sched_x[30:0], w_sched_x[31]};
        w_wt      = (r_t < 7'd16) ? r_w[w_widx] : w_sched;
        if (r_t < 7'd20) begin
            w_f = (r_b & r_c) | (~r_b & r_d);
            w_k = 32'h5A827999;
        end else if (r_t < 7'd40) begin
            w_f = r_b ^ r_c ^ r_d;
            w_k = 32'h6ED9EBA1;
        end else if (r_t < 7'd60) begin
            w_f = (r_b & r_c) | (r_b & r_d) | (r_c & r_d);
            w_k = 32'h8F1BBCDC;
        end else begin
            w_f = r_b ^ r_c ^ r_d;
            w_k = 32'hCA62C1D6;
        end
        w_temp = {r_a[26:0], r_a[31:27]} + w_f + r_e + w_k + w_wt;
        w_h0n  = r_h0 + r_a;
        w_h1n  = r_h1 + r_b;
        w_h2n  = r_h2 + r_c;
        w_h3n  = r_h3 + r_d;
        w_h4n  = r_h4 + r_e;
    end

    // Control FSM and datapath state; address, hash and done are registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_base  <= 16'h0;
            r_size  <= 32'h0;
            r_nblk  <= 11'h0;
            r_blk   <= 11'h0;
            r_issue <= 5'h0;
            r_recv  <= 5'h0;
            r_p1    <= 1'b0;
            r_p2    <= 1'b0;
            r_addr  <= 16'h0;
            r_t     <= 7'h0;
            r_a     <= 32'h0;
            r_b     <= 32'h0;
            r_c     <= 32'h0;
            r_d     <= 32'h0;
            r_e     <= 32'h0;
            r_h0    <= 32'h0;
            r_h1    <= 32'h0;
            r_h2    <= 32'h0;
            r_h3    <= 32'h0;
            r_h4    <= 32'h0;
            r_hash  <= 160'h0;
            r_done  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= 32'h0;
            end
        end else begin
            // Read pipeline: address out at issue, data sampled two edges later.
            r_p1 <= w_do_issue;
            r_p2 <= r_p1;
            if (w_do_issue) begin
                r_addr  <= {w_addr_sum[15:2], 2'b00};
                r_issue <= r_issue + 5'd1;
            end

            case (r_state)
                StIdle, StDone: begin
                    if (start_hash) begin
                        r_base  <= message_addr[15:0];
                        r_size  <= message_size;
                        r_nblk  <= w_nblk_new;
                        r_blk   <= 11'h0;
                        r_issue <= 5'h0;
                        r_recv  <= 5'h0;
                        r_done  <= 1'b0;
                        r_h0    <= H0_INIT;
                        r_h1    <= H1_INIT;
                        r_h2    <= H2_INIT;
                        r_h3    <= H3_INIT;
                        r_h4    <= H4_INIT;
                        r_state <= StRead;
                    end
                end
                StRead: begin
                    if (r_p2) begin
                        r_w[r_recv[3:0]] <= w_recv_word;
                        r_recv           <= r_recv + 5'd1;
                    end else if (!w_do_issue && !r_p1) begin
                        if (r_recv[4]) begin
                            r_a     <= r_h0;
                            r_b     <= r_h1;
                            r_c     <= r_h2;
                            r_d     <= r_h3;
                            r_e     <= r_h4;
                            r_t     <= 7'h0;
                            r_state <= StRounds;
                        end else begin
                            r_state <= StPad;
                        end
                    end
                end
                StPad: begin
                    r_w[r_recv[3:0]] <= w_pad_word;
                    r_recv           <= r_recv + 5'd1;
                    if (r_recv[3:0] == 4'd15) begin
                        r_a     <= r_h0;
                        r_b     <= r_h1;
                        r_c     <= r_h2;
                        r_d     <= r_h3;
                        r_e     <= r_h4;
                        r_t     <= 7'h0;
                        r_state <= StRounds;
                    end
                end
                StRounds: begin
                    r_e <= r_d;
                    r_d <= r_c;
                    r_c <= {r_b[1:0], r_b[31:2]};
                    r_b <= r_a;
                    r_a <= w_temp;
                    if (r_t >= 7'd16) begin
                        r_w[w_widx] <= w_sched;
                    end
                    r_t <= r_t + 7'd1;
                    if (r_t == 7'd79) begin
                        r_state <= StUpdate;
                    end
                end
                StUpdate: begin
                    r_h0 <= w_h0n;
                    r_h1 <= w_h1n;
                    r_h2 <= w_h2n;
                    r_h3 <= w_h3n;
                    r_h4 <= w_h4n;
                    if (w_last_blk) begin
                        r_hash  <= {w_h0n, w_h1n, w_h2n, w_h3n, w_h4n};
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_blk   <= r_blk + 11'd1;
                        r_issue <= 5'h0;
                        r_recv  <= 5'h0;
                        r_state <= StRead;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_hash_core.sv
// Self-checking bench for sha1_hash_core: SRAM model, byte-level SHA-1 reference,
// directed runs and a per-cycle digest compare while done is high.
module tb_sha1_hash_core;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_hash;
    logic [31:0]  message_addr;
    logic [31:0]  message_size;
    logic [159:0] hash;
    logic         done;

    sha1_hash_core_if mem_if ();

    sha1_hash_core dut (
        .clk          (clk),
        .reset        (reset),
        .start_hash   (start_hash),
        .message_addr (message_addr),
        .message_size (message_size),
        .hash         (hash),
        .done         (done),
        .port_a       (mem_if)
    );

    always #5 clk = ~clk;

    logic [31:0]  mem [16384];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic         exp_valid;
    logic [159:0] exp_hash;
    logic         bus_bad;

    // SRAM: captures the address on a clock edge and returns the word after it.
    always @(posedge mem_if.port_A_clk) begin
        mem_if.port_A_data_out <= mem[mem_if.port_A_addr[15:2]];
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference SHA-1 over the bytes in mem, padded the textbook way.
    function automatic logic [159:0] sha1_model(input int unsigned base, input int unsigned len);
        byte unsigned msg[$];
        logic [31:0]  wd;
        logic [13:0]  widx;
        logic [31:0]  w [80];
        logic [31:0]  h [5];
        logic [31:0]  a, b, c, d, e, f, k, tmp;
        logic [63:0]  bitlen;
        int           nblk;
        for (int n = 0; n < int'(len); n++) begin
            widx = 14'((base >> 2) + (n >> 2));
            wd   = mem[widx];
            msg.push_back(wd[8*(n%4) +: 8]);
        end
        msg.push_back(8'h80);
        while ((msg.size() % 64) != 56) msg.push_back(8'h00);
        bitlen = 64'(len) << 3;
        for (int i = 7; i >= 0; i--) msg.push_back(bitlen[8*i +: 8]);
        h[0] = 32'h67452301; h[1] = 32'hEFCDAB89; h[2] = 32'h98BADCFE;
        h[3] = 32'h10325476; h[4] = 32'hC3D2E1F0;
        nblk = msg.size() / 64;
        for (int blk = 0; blk < nblk; blk++) begin
            for (int t = 0; t < 16; t++) begin
                w[t] = {msg[64*blk+4*t], msg[64*blk+4*t+1], msg[64*blk+4*t+2],
                        msg[64*blk+4*t+3]};
            end
            for (int t = 16; t < 80; t++) begin
                tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
                w[t] = {tmp[30:0], tmp[31]};
            end
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
            for (int t = 0; t < 80; t++) begin
                if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
                else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
                else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
                else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
                tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
                e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e;
        end
        return {h[0], h[1], h[2], h[3], h[4]};
    endfunction

    // Compare process: digest must equal the expectation on every cycle done is high.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mem_if.port_A_we !== 1'b0 || mem_if.port_A_addr[1:0] !== 2'b00 ||
                mem_if.port_A_data_in !== 32'h0 || mem_if.port_A_clk !== clk) begin
                bus_bad = 1'b1;
            end
            if (exp_valid && done === 1'b1) begin
                chk("digest", hash, exp_hash);
            end
        end
    end

    task automatic run_hash(input string name, input logic [15:0] addr,
                            input logic [31:0] size, input int hold);
        logic [159:0] m;
        int           cyc;
        m = sha1_model(int'(addr), size);
        @(posedge clk);
        #1;
        exp_valid    = 1'b0;
        bus_bad      = 1'b0;
        message_addr = {16'h0, addr};
        message_size = size;
        start_hash   = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        start_hash = 1'b0;
        chk({name, "_done_low_after_start"}, 160'(done), 160'(1'b0));
        exp_hash  = m;
        exp_valid = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, "_done_seen"}, 160'(done), 160'(1'b1));
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_bus_rules"}, 160'(bus_bad), 160'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string       s;
        logic [31:0] p;
        logic [13:0] wi;
        int          sizes [7];

        reset        = 1'b1;
        start_hash   = 1'b0;
        message_addr = 32'h0;
        message_size = 32'h0;
        exp_valid    = 1'b0;
        exp_hash     = 160'h0;
        bus_bad      = 1'b0;

        // Background fill so unmasked or stray reads corrupt the digest.
        for (int i = 0; i < 16384; i++) mem[i] = 32'hA5C30000 | 32'(i);
        mem[0] = 32'h00636261;
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        for (int i = 0; i < 56; i++) begin
            wi = 14'(64 + i / 4);
            mem[wi][8*(i%4) +: 8] = s[i];
        end
        p = 32'h01234567;
        for (int k = 0; k < 128; k++) begin
            mem[256 + k] = p;
            p = {p[30:0], p[31]};
        end

        #12;
        chk("reset_hash", hash, 160'h0);
        chk("reset_done", 160'(done), 160'(1'b0));
        chk("reset_addr", 160'(mem_if.port_A_addr), 160'h0);
        chk("reset_we", 160'(mem_if.port_A_we), 160'h0);
        chk("reset_wdata", 160'(mem_if.port_A_data_in), 160'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        chk("model_empty", sha1_model(0, 0), 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);
        chk("model_abc", sha1_model(0, 3), 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
        chk("model_56", sha1_model(32'h100, 56), 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);

        run_hash("empty", 16'h0000, 32'd0, 1);
        chk("empty_literal", hash, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);
        run_hash("abc", 16'h0000, 32'd3, 1);
        chk("abc_literal", hash, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
        run_hash("two_block", 16'h0100, 32'd56, 1);
        chk("two_block_literal", hash, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);

        sizes = '{55, 56, 57, 62, 63, 64, 511};
        foreach (sizes[i]) begin
            run_hash($sformatf("pattern_%0d", sizes[i]), 16'h0400, 32'(sizes[i]), 1);
        end

        // Abort mid-rounds: outputs must clear as soon as reset rises.
        @(posedge clk);
        #1;
        exp_valid    = 1'b0;
        message_addr = 32'h0;
        message_size = 32'd3;
        start_hash   = 1'b1;
        @(posedge clk);
        #1;
        start_hash = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_hash", hash, 160'h0);
        chk("abort_done", 160'(done), 160'(1'b0));
        chk("abort_addr", 160'(mem_if.port_A_addr), 160'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_hash("abc_after_abort", 16'h0000, 32'd3, 1);
        chk("abc_after_abort_literal", hash, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);

        run_hash("b2b_abc", 16'h0000, 32'd3, 2);
        run_hash("b2b_empty", 16'h0000, 32'd0, 2);
        chk("b2b_empty_literal", hash, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
